// File: rtl/sprite_addr_gen_multi.sv
// rtl/sprite_addr_gen_multi.sv - multi-sprite pipelined ROM address generator
//
// Tracks N_SPR equally sized sprites, each with a double-buffered position and
// enable (shadow written at any time, active loaded only on frame_start) plus an
// animation frame index. For each VGA pixel it reports, two clocks later, the ROM
// address of the lowest-index sprite covering that pixel.
//
// Ports:
//   clk          pixel-domain clock
//   rst_n        asynchronous active-low reset
//   h_cnt/v_cnt  current pixel column / row
//   frame_start  one-cycle pulse at start of vertical blanking (commit + animation tick)
//   wr_en        shadow-register write strobe
//   wr_idx       sprite index to write (indices >= N_SPR are ignored)
//   wr_x/wr_y    new start position
//   wr_vis       new enable bit
//   anim_en      per-sprite animation enable
//   pixel_addr   ROM address of winning sprite pixel (registered)
//   valid        a sprite covers the pixel (registered)
//   sprite_id    index of winning sprite (registered)

module sprite_addr_gen_multi #(
    parameter int N_SPR    = 4,
    parameter int SPR_W    = 40,
    parameter int SPR_H    = 40,
    parameter int N_FRM    = 2,
    parameter int ANIM_DIV = 8,
    parameter int ADDR_W   = 17
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [9:0]        h_cnt,
    input  logic [9:0]        v_cnt,
    input  logic              frame_start,
    input  logic              wr_en,
    input  logic [2:0]        wr_idx,
    input  logic [9:0]        wr_x,
    input  logic [9:0]        wr_y,
    input  logic              wr_vis,
    input  logic [N_SPR-1:0]  anim_en,
    output logic [ADDR_W-1:0] pixel_addr,
    output logic              valid,
    output logic [2:0]        sprite_id
);

    localparam int          FRAME_SZ  = SPR_W * SPR_H;
    localparam logic [7:0]  PRESC_TOP = 8'(ANIM_DIV - 1);
    localparam logic [1:0]  FRM_TOP   = 2'(N_FRM - 1);
    localparam logic [10:0] SPR_W_11  = 11'(SPR_W);
    localparam logic [10:0] SPR_H_11  = 11'(SPR_H);

    // Shadow (CPU-facing) and active (display-facing) sprite state
    logic [9:0] sh_x    [N_SPR];
    logic [9:0] sh_y    [N_SPR];
    logic       sh_vis  [N_SPR];
    logic [9:0] act_x   [N_SPR];
    logic [9:0] act_y   [N_SPR];
    logic       act_vis [N_SPR];
    logic [1:0] frm     [N_SPR];
    logic [7:0] presc;

    // Stage 1 pipeline registers
    logic [N_SPR-1:0]  hit_q;
    logic [ADDR_W-1:0] off_q [N_SPR];
    logic [1:0]        frm_q [N_SPR];

    // Stage 1 combinational results
    logic [N_SPR-1:0]  hit_c;
    logic [ADDR_W-1:0] off_c [N_SPR];

    // Stage 2 combinational select
    logic              sel_hit;
    logic [2:0]        sel_id;
    logic [ADDR_W-1:0] sel_addr;

    // ------------------------------------------------------------------
    // Sprite state: shadow writes, frame_start commit, animation stepping.
    // The commit reads the shadow value from before this edge, so a write
    // coinciding with frame_start only reaches the active copy one
    // frame_start later.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_SPR; i++) begin
                sh_x[i]    <= '0;
                sh_y[i]    <= '0;
                sh_vis[i]  <= 1'b0;
                act_x[i]   <= '0;
                act_y[i]   <= '0;
                act_vis[i] <= 1'b0;
                frm[i]     <= '0;
            end
            presc <= '0;
        end else begin
            for (int i = 0; i < N_SPR; i++) begin
                // Indices >= N_SPR never match, so out-of-range writes are dropped.
                if (wr_en && (wr_idx == 3'(i))) begin
                    sh_x[i]   <= wr_x;
                    sh_y[i]   <= wr_y;
                    sh_vis[i] <= wr_vis;
                end
                if (frame_start) begin
                    act_x[i]   <= sh_x[i];
                    act_y[i]   <= sh_y[i];
                    act_vis[i] <= sh_vis[i];
                end
            end
            if (frame_start) begin
                if (presc == PRESC_TOP) begin
                    presc <= '0;
                    for (int i = 0; i < N_SPR; i++) begin
                        if (anim_en[i]) begin
                            frm[i] <= (frm[i] == FRM_TOP) ? 2'd0 : frm[i] + 2'd1;
                        end
                    end
                end else begin
                    presc <= presc + 8'd1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: per-sprite hit test and in-sprite offset.
    // Bounds are compared in 11 bits so x+SPR_W past 1023 cannot wrap
    // around and cover the left edge of the screen.
    // ------------------------------------------------------------------
    always_comb begin
        hit_c = '0;
        for (int i = 0; i < N_SPR; i++) begin
            logic [10:0] h11, v11, x11, y11;
            logic [9:0]  dx, dy;
            h11 = {1'b0, h_cnt};
            v11 = {1'b0, v_cnt};
            x11 = {1'b0, act_x[i]};
            y11 = {1'b0, act_y[i]};
            hit_c[i] = act_vis[i]
                     && (h11 >= x11) && (h11 < x11 + SPR_W_11)
                     && (v11 >= y11) && (v11 < y11 + SPR_H_11);
            // Only meaningful when hit_c[i]; garbage otherwise and never selected.
            dx = h_cnt - act_x[i];
            dy = v_cnt - act_y[i];
            off_c[i] = ADDR_W'(dx) + ADDR_W'(dy) * ADDR_W'(SPR_W);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_q <= '0;
            for (int i = 0; i < N_SPR; i++) begin
                off_q[i] <= '0;
                frm_q[i] <= '0;
            end
        end else begin
            hit_q <= hit_c;
            for (int i = 0; i < N_SPR; i++) begin
                off_q[i] <= off_c[i];
                // Frame sampled together with the offset so a mid-line
                // animation step only affects pixels entering after it.
                frm_q[i] <= frm[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: priority select. Scanning from the highest index down lets
    // the lowest-index hit overwrite the others.
    // ------------------------------------------------------------------
    always_comb begin
        sel_hit  = 1'b0;
        sel_id   = '0;
        sel_addr = '0;
        for (int i = N_SPR - 1; i >= 0; i--) begin
            if (hit_q[i]) begin
                sel_hit  = 1'b1;
                sel_id   = 3'(i);
                sel_addr = ADDR_W'((i * N_FRM + int'(frm_q[i])) * FRAME_SZ) + off_q[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_addr <= '0;
            valid      <= 1'b0;
            sprite_id  <= '0;
        end else begin
            pixel_addr <= sel_addr;
            valid      <= sel_hit;
            sprite_id  <= sel_id;
        end
    end

endmodule

// File: tb/tb_sprite_addr_gen_multi.sv
// tb/tb_sprite_addr_gen_multi.sv - self-checking bench for sprite_addr_gen_multi

module tb_sprite_addr_gen_multi;

    localparam int N_SPR    = 4;
    localparam int SPR_W    = 40;
    localparam int SPR_H    = 40;
    localparam int N_FRM    = 2;
    localparam int ANIM_DIV = 8;
    localparam int ADDR_W   = 17;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [9:0]        h_cnt = '0;
    logic [9:0]        v_cnt = '0;
    logic              frame_start = 1'b0;
    logic              wr_en = 1'b0;
    logic [2:0]        wr_idx = '0;
    logic [9:0]        wr_x = '0;
    logic [9:0]        wr_y = '0;
    logic              wr_vis = 1'b0;
    logic [N_SPR-1:0]  anim_en = '0;
    logic [ADDR_W-1:0] pixel_addr;
    logic              valid;
    logic [2:0]        sprite_id;

    sprite_addr_gen_multi #(
        .N_SPR(N_SPR), .SPR_W(SPR_W), .SPR_H(SPR_H),
        .N_FRM(N_FRM), .ANIM_DIV(ANIM_DIV), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .h_cnt(h_cnt), .v_cnt(v_cnt),
        .frame_start(frame_start), .wr_en(wr_en), .wr_idx(wr_idx),
        .wr_x(wr_x), .wr_y(wr_y), .wr_vis(wr_vis), .anim_en(anim_en),
        .pixel_addr(pixel_addr), .valid(valid), .sprite_id(sprite_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit valid;
        int id;
        int addr;
    } exp_t;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Reference model: sprite state as plain integers
    int m_sh_x [N_SPR];
    int m_sh_y [N_SPR];
    bit m_sh_v [N_SPR];
    int m_x    [N_SPR];
    int m_y    [N_SPR];
    bit m_v    [N_SPR];
    int m_frm  [N_SPR];
    int m_presc;

    exp_t exp_cur  = '{0, 0, 0};
    exp_t exp_prev = '{0, 0, 0};

    function automatic exp_t model_px(int h, int v);
        exp_t e = '{0, 0, 0};
        for (int i = 0; i < N_SPR; i++) begin
            if (m_v[i] && h >= m_x[i] && h < m_x[i] + SPR_W &&
                v >= m_y[i] && v < m_y[i] + SPR_H) begin
                e.valid = 1;
                e.id    = i;
                e.addr  = (i * N_FRM + m_frm[i]) * SPR_W * SPR_H
                        + (h - m_x[i]) + (v - m_y[i]) * SPR_W;
                return e;
            end
        end
        return e;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N_SPR; i++) begin
            m_sh_x[i] = 0; m_sh_y[i] = 0; m_sh_v[i] = 0;
            m_x[i] = 0; m_y[i] = 0; m_v[i] = 0; m_frm[i] = 0;
        end
        m_presc = 0;
    endtask

    task automatic model_edge(bit fs, bit we, int idx, int x, int y, bit vis);
        if (fs) begin
            for (int i = 0; i < N_SPR; i++) begin
                m_x[i] = m_sh_x[i]; m_y[i] = m_sh_y[i]; m_v[i] = m_sh_v[i];
            end
            if (m_presc == ANIM_DIV - 1) begin
                m_presc = 0;
                for (int i = 0; i < N_SPR; i++)
                    if (anim_en[i]) m_frm[i] = (m_frm[i] + 1) % N_FRM;
            end else begin
                m_presc++;
            end
        end
        if (we && idx < N_SPR) begin
            m_sh_x[idx] = x; m_sh_y[idx] = y; m_sh_v[idx] = vis;
        end
    endtask

    // One clock of stimulus: drive at the falling edge, record what the
    // pixel must produce, then advance the model past the coming edge.
    task automatic step(int h, int v, bit fs, bit we, int idx, int x, int y, bit vis);
        @(negedge clk);
        h_cnt = 10'(h); v_cnt = 10'(v);
        frame_start = fs; wr_en = we; wr_idx = 3'(idx);
        wr_x = 10'(x); wr_y = 10'(y); wr_vis = vis;
        exp_cur = model_px(h, v);
        model_edge(fs, we, idx, x, y, vis);
    endtask

    task automatic wr(int idx, int x, int y, bit vis);
        step(0, 0, 0, 1, idx, x, y, vis);
    endtask

    task automatic fs_pulse();
        step(0, 0, 1, 0, 0, 0, 0, 0);
    endtask

    // Output of each pixel appears after the second rising edge following it
    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            checks++;
            if (valid !== exp_prev.valid || int'(sprite_id) != exp_prev.id ||
                int'(pixel_addr) != exp_prev.addr) begin
                errors++;
                $display("FAIL pipe t=%0t: got valid=%0d id=%0d addr=%0d, want valid=%0d id=%0d addr=%0d",
                         $time, valid, sprite_id, pixel_addr, exp_prev.valid, exp_prev.id, exp_prev.addr);
            end
        end
        exp_prev = exp_cur;
    end

    task automatic probe(string nm, int h, int v, bit ev, int eid, int eaddr);
        step(h, v, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #2;
        checks++;
        if (valid !== ev || int'(sprite_id) != eid || int'(pixel_addr) != eaddr) begin
            errors++;
            $display("FAIL %s: got valid=%0d id=%0d addr=%0d, want valid=%0d id=%0d addr=%0d",
                     nm, valid, sprite_id, pixel_addr, ev, eid, eaddr);
        end
    endtask

    // Assert reset away from the clock edge and check the asynchronous clear
    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        chk_en = 1'b0;
        #1;
        checks++;
        if (valid !== 1'b0 || sprite_id !== 3'd0 || pixel_addr !== '0) begin
            errors++;
            $display("FAIL async_reset: got valid=%0d id=%0d addr=%0d, want 0 0 0",
                     valid, sprite_id, pixel_addr);
        end
        h_cnt = '0; v_cnt = '0; frame_start = 0; wr_en = 0;
        model_reset();
        exp_cur = '{0, 0, 0};
        exp_prev = '{0, 0, 0};
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk_en = 1'b1;
    endtask

    initial begin
        model_reset();
        #12;
        do_reset();

        // No commit yet: nothing valid
        for (int h = 95; h < 105; h++) step(h, 50, 0, 0, 0, 0, 0, 0);
        probe("no_commit", 100, 50, 0, 0, 0);

        // Single sprite
        wr(0, 100, 50, 1);
        fs_pulse();
        for (int h = 99; h <= 140; h++) step(h, 50, 0, 0, 0, 0, 0, 0);
        probe("left_out", 99, 50, 0, 0, 0);
        probe("left_in", 100, 50, 1, 0, 0);
        probe("right_in", 139, 50, 1, 0, 39);
        probe("right_out", 140, 50, 0, 0, 0);
        probe("bottom_in", 100, 89, 1, 0, 1560);
        probe("bottom_out", 100, 90, 0, 0, 0);

        // Priority
        wr(2, 120, 60, 1);
        fs_pulse();
        probe("prio_0", 120, 60, 1, 0, 420);
        wr(0, 100, 50, 0);
        fs_pulse();
        probe("prio_2", 120, 60, 1, 2, 6400);

        // Shadow / commit
        wr(1, 300, 200, 1);
        probe("shadow_hold", 300, 200, 0, 0, 0);
        fs_pulse();
        probe("shadow_commit", 300, 200, 1, 1, 3200);
        step(0, 0, 1, 1, 1, 400, 200, 1);
        probe("coincide_new", 400, 200, 0, 0, 0);
        probe("coincide_old", 300, 200, 1, 1, 3200);
        fs_pulse();
        probe("coincide_late", 400, 200, 1, 1, 3200);

        // Out-of-range index and right-edge clipping
        step(0, 0, 0, 1, 7, 0, 0, 1);
        fs_pulse();
        probe("idx7", 0, 0, 0, 0, 0);
        wr(3, 1000, 0, 1);
        fs_pulse();
        for (int h = 995; h < 1024; h++) step(h, 0, 0, 0, 0, 0, 0, 0);
        for (int h = 0; h < 20; h++) step(h, 0, 0, 0, 0, 0, 0, 0);
        probe("edge_1023", 1023, 0, 1, 3, 9623);
        probe("edge_nowrap", 5, 0, 0, 0, 0);

        // Reset mid-stream while a sprite is covering the pixel
        step(1010, 10, 0, 0, 0, 0, 0, 0);
        step(1011, 10, 0, 0, 0, 0, 0, 0);
        do_reset();
        for (int h = 995; h < 1024; h++) step(h, 10, 0, 0, 0, 0, 0, 0);
        probe("after_reset", 1010, 10, 0, 0, 0);

        // Animation
        anim_en = 4'b0001;
        wr(0, 100, 50, 1);
        wr(1, 300, 200, 1);
        fs_pulse();
        for (int k = 0; k < 6; k++) fs_pulse();
        probe("anim_7", 100, 50, 1, 0, 0);
        fs_pulse();
        probe("anim_8", 100, 50, 1, 0, 1600);
        probe("anim_hold", 300, 200, 1, 1, 3200);
        for (int k = 0; k < 8; k++) fs_pulse();
        probe("anim_16", 100, 50, 1, 0, 0);

        // Randomized traffic against the model
        for (int n = 0; n < 4000; n++) begin
            int j, h, v;
            bit fs, we;
            if ($urandom_range(0, 63) == 0) anim_en = 4'($urandom);
            j = $urandom_range(0, N_SPR - 1);
            if ($urandom_range(0, 3) == 0) begin
                h = $urandom_range(0, 1023);
                v = $urandom_range(0, 1023);
            end else begin
                h = m_x[j] + $urandom_range(0, SPR_W + 1) - 1;
                v = m_y[j] + $urandom_range(0, SPR_H + 1) - 1;
                if (h < 0) h = 0;
                if (h > 1023) h = 1023;
                if (v < 0) v = 0;
                if (v > 1023) v = 1023;
            end
            fs = ($urandom_range(0, 9) == 0);
            we = ($urandom_range(0, 7) == 0);
            step(h, v, fs, we, $urandom_range(0, 7),
                 ($urandom_range(0, 3) == 0) ? $urandom_range(980, 1023) : $urandom_range(0, 900),
                 $urandom_range(0, 900), ($urandom_range(0, 3) != 0));
        end
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #3;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
